rpc2_ctrl_axi_addr_arbiter: RTL and testbench



---
 rtl/rpc2_ctrl_axi_addr_arbiter.sv | 121 ++++++++++++
 tb/tb_rpc2_ctrl_axi_addr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpc2_ctrl_axi_addr_arbiter.sv
// Merges the AXI write- and read-address command streams into the ADR FIFO through one registered stage.
// Define RPC2_CTRL_ADR_ARB_STAT_EN to build in the saturating grant counters (otherwise tied to zero).
module rpc2_ctrl_axi_addr_arbiter #(
  parameter int C_ADR_WIDTH    = 46,
  parameter int C_ARB_MODE     = 0,
  parameter int C_STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   aw_valid,
  input  logic [C_ADR_WIDTH-1:0] aw_din,
  output logic                   aw_ready,
  input  logic                   ar_valid,
  input  logic [C_ADR_WIDTH-1:0] ar_din,
  output logic                   ar_ready,
  input  logic                   adr_full,
  output logic                   adr_wr_en,
  output logic [C_ADR_WIDTH:0]   adr_din,
  output logic                   last_grant,
  output logic [15:0]            stat_aw_cnt,
  output logic [15:0]            stat_ar_cnt
);

  localparam logic [3:0] LP_STARVE_LIMIT = 4'(C_STARVE_LIMIT);

  logic                 r_out_valid;
  logic [C_ADR_WIDTH:0] r_out_data;
  logic                 r_last_grant;
  logic [3:0]           r_starve_cnt;

  logic w_load;
  logic w_gnt_aw;
  logic w_gnt_ar;

  // The stage takes a new command when it is empty or its current one drains this cycle.
  assign w_load = ~r_out_valid | ~adr_full;

  always_comb begin
    w_gnt_aw = 1'b0;
    w_gnt_ar = 1'b0;
    if (C_ARB_MODE == 1) begin
      if (aw_valid && ar_valid) begin
        w_gnt_aw = r_last_grant;
        w_gnt_ar = ~r_last_grant;
      end else begin
        w_gnt_aw = aw_valid;
        w_gnt_ar = ar_valid;
      end
    end else if ((C_ARB_MODE == 2) && ar_valid && (r_starve_cnt == LP_STARVE_LIMIT)) begin
      w_gnt_ar = 1'b1;
    end else begin
      w_gnt_aw = aw_valid;
      w_gnt_ar = ar_valid & ~aw_valid;
    end
  end

  assign aw_ready   = w_load & w_gnt_aw;
  assign ar_ready   = w_load & w_gnt_ar;
  assign adr_wr_en  = r_out_valid & ~adr_full;
  assign adr_din    = r_out_data;
  assign last_grant = r_last_grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      if (ar_ready) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= {1'b1, ar_din};
        r_last_grant <= 1'b1;
      end else if (aw_ready) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= {1'b0, aw_din};
        r_last_grant <= 1'b0;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // Counts write wins over a waiting read; frozen while the stage is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_load) begin
      if (!ar_valid || ar_ready) begin
        r_starve_cnt <= 4'd0;
      end else if (aw_ready && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

`ifdef RPC2_CTRL_ADR_ARB_STAT_EN
  logic [15:0] r_stat_aw_cnt;
  logic [15:0] r_stat_ar_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_aw_cnt <= 16'h0000;
      r_stat_ar_cnt <= 16'h0000;
    end else begin
      if (aw_ready && (r_stat_aw_cnt != 16'hFFFF)) begin
        r_stat_aw_cnt <= r_stat_aw_cnt + 16'd1;
      end
      if (ar_ready && (r_stat_ar_cnt != 16'hFFFF)) begin
        r_stat_ar_cnt <= r_stat_ar_cnt + 16'd1;
      end
    end
  end

  assign stat_aw_cnt = r_stat_aw_cnt;
  assign stat_ar_cnt = r_stat_ar_cnt;
`else
  assign stat_aw_cnt = 16'h0000;
  assign stat_ar_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rpc2_ctrl_axi_addr_arbiter.sv
// Bench for rpc2_ctrl_axi_addr_arbiter: three instances (modes 0, 1, 2 with starve limit 3) share stimulus,
// each with its own requester payloads and an in-order scoreboard of accepted commands.
module tb_rpc2_ctrl_axi_addr_arbiter;

  localparam int W  = 46;
  localparam int ND = 3;

  logic clk;
  logic reset_n;
  logic awValid;
  logic arValid;
  logic adrFull;

  logic [W-1:0] awDin      [ND];
  logic [W-1:0] arDin      [ND];
  logic         awReady    [ND];
  logic         arReady    [ND];
  logic         adrWrEn    [ND];
  logic [W:0]   adrDin     [ND];
  logic         lastGrant  [ND];
  logic [15:0]  statAw     [ND];
  logic [15:0]  statAr     [ND];

  int unsigned awSeq [ND];
  int unsigned arSeq [ND];

  logic [W:0] expQ   [ND][$];
  bit         gntLog [ND][$];
  logic [W:0] monExp;

  int checks;
  int failures;

  for (genvar g = 0; g < ND; g++) begin : gDut
    rpc2_ctrl_axi_addr_arbiter #(
      .C_ADR_WIDTH   (W),
      .C_ARB_MODE    (g),
      .C_STARVE_LIMIT(3)
    ) uDut (
      .clk        (clk),
      .reset_n    (reset_n),
      .aw_valid   (awValid),
      .aw_din     (awDin[g]),
      .aw_ready   (awReady[g]),
      .ar_valid   (arValid),
      .ar_din     (arDin[g]),
      .ar_ready   (arReady[g]),
      .adr_full   (adrFull),
      .adr_wr_en  (adrWrEn[g]),
      .adr_din    (adrDin[g]),
      .last_grant (lastGrant[g]),
      .stat_aw_cnt(statAw[g]),
      .stat_ar_cnt(statAr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each requester presents a unique payload and only moves on once its command is accepted.
  always_comb begin
    for (int k = 0; k < ND; k++) begin
      awDin[k] = {2'b01, 12'(k), awSeq[k]};
      arDin[k] = {2'b10, 12'(k), arSeq[k]};
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (reset_n && awValid && awReady[k]) awSeq[k] <= awSeq[k] + 1;
      if (reset_n && arValid && arReady[k]) arSeq[k] <= arSeq[k] + 1;
    end
  end

  // Mid-cycle scoreboard: pop and compare on every push, then record this cycle's grant.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < ND; k++) begin
        if (adrWrEn[k]) begin
          checks++;
          if (expQ[k].size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_dut%0d: push of %h with no command expected", k, adrDin[k]);
          end else begin
            monExp = expQ[k].pop_front();
            if (adrDin[k] !== monExp) begin
              failures++;
              $display("[TB] FAIL scoreboard_dut%0d: adr_din=%h expected %h", k, adrDin[k], monExp);
            end
          end
        end
        if (awReady[k]) begin
          expQ[k].push_back({1'b0, awDin[k]});
          gntLog[k].push_back(1'b0);
        end
        if (arReady[k]) begin
          expQ[k].push_back({1'b1, arDin[k]});
          gntLog[k].push_back(1'b1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flushAll();
    for (int k = 0; k < ND; k++) begin
      expQ[k].delete();
      gntLog[k].delete();
    end
  endtask

  task automatic drainAndCheck(input string name);
    awValid = 1'b0;
    arValid = 1'b0;
    adrFull = 1'b0;
    repeat (3) step();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin
        failures++;
        $display("[TB] FAIL %s_drain_dut%0d: %0d commands left expected 0", name, k, expQ[k].size());
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    awValid = 1'b0;
    arValid = 1'b0;
    adrFull = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (adrWrEn[k] !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_wr_en_dut%0d: got %b expected 0", k, adrWrEn[k]);
      end
      checks++;
      if (lastGrant[k] !== 1'b1) begin
        failures++; $display("[TB] FAIL reset_last_grant_dut%0d: got %b expected 1", k, lastGrant[k]);
      end
      checks++;
      if (adrDin[k] !== '0) begin
        failures++; $display("[TB] FAIL reset_adr_din_dut%0d: got %h expected 0", k, adrDin[k]);
      end
      checks++;
      if ((statAw[k] !== 16'h0) || (statAr[k] !== 16'h0)) begin
        failures++; $display("[TB] FAIL reset_stats_dut%0d: got %h/%h expected 0/0", k, statAw[k], statAr[k]);
      end
    end
    flushAll();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_contention();
    int  pushes [ND];
    bit  expDir;
    for (int k = 0; k < ND; k++) pushes[k] = 0;
    flushAll();
    step();
    awValid = 1'b1;
    arValid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        if (c == 1) begin
          checks++;
          if (adrWrEn[k] !== 1'b0) begin
            failures++; $display("[TB] FAIL latency_dut%0d: wr_en=%b in grant cycle expected 0", k, adrWrEn[k]);
          end
        end else begin
          pushes[k] += int'(adrWrEn[k]);
        end
      end
    end
    step();
    awValid = 1'b0;
    arValid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      pushes[k] += int'(adrWrEn[k]);
      checks++;
      if (pushes[k] != 8) begin
        failures++; $display("[TB] FAIL throughput_dut%0d: %0d pushes expected 8", k, pushes[k]);
      end
      checks++;
      if (gntLog[k].size() != 8) begin
        failures++; $display("[TB] FAIL grant_count_dut%0d: %0d grants expected 8", k, gntLog[k].size());
      end
      for (int i = 0; i < 8 && i < gntLog[k].size(); i++) begin
        expDir = (k == 0) ? 1'b0 : (k == 1) ? (i % 2 == 1) : (i % 4 == 3);
        checks++;
        if (gntLog[k][i] !== expDir) begin
          failures++; $display("[TB] FAIL grant_order_dut%0d_%0d: dir %b expected %b", k, i, gntLog[k][i], expDir);
        end
      end
    end
    drainAndCheck("contention");
  endtask

  task automatic test_single_requester();
    flushAll();
    step();
    arValid = 1'b1;
    repeat (3) step();
    arValid = 1'b0;
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (gntLog[k].size() != 3) begin
        failures++; $display("[TB] FAIL single_count_dut%0d: %0d grants expected 3", k, gntLog[k].size());
      end
      for (int i = 0; i < gntLog[k].size(); i++) begin
        checks++;
        if (gntLog[k][i] !== 1'b1) begin
          failures++; $display("[TB] FAIL single_dir_dut%0d_%0d: dir %b expected 1", k, i, gntLog[k][i]);
        end
      end
    end
    drainAndCheck("single");
  endtask

  task automatic test_backpressure();
    flushAll();
    step();
    adrFull = 1'b1;
    awValid = 1'b1;
    arValid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if ((int'(awReady[k]) + int'(arReady[k])) != 1 || adrWrEn[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_capture_dut%0d: ready=%b%b wr_en=%b expected one ready, wr_en 0",
                 k, awReady[k], arReady[k], adrWrEn[k]);
      end
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (awReady[k] !== 1'b0 || arReady[k] !== 1'b0 || adrWrEn[k] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bp_hold_dut%0d_c%0d: ready=%b%b wr_en=%b expected 00 and 0",
                   k, c, awReady[k], arReady[k], adrWrEn[k]);
        end
        checks++;
        if (expQ[k].size() != 1) begin
          failures++; $display("[TB] FAIL bp_captured_dut%0d_c%0d: %0d held expected 1", k, c, expQ[k].size());
        end else if (adrDin[k] !== expQ[k][0]) begin
          failures++; $display("[TB] FAIL bp_stable_dut%0d_c%0d: adr_din=%h expected %h", k, c, adrDin[k], expQ[k][0]);
        end
      end
    end
    step();
    adrFull = 1'b0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (adrWrEn[k] !== 1'b1 || (awReady[k] | arReady[k]) !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_release_dut%0d: wr_en=%b ready=%b%b expected push with regrant",
                 k, adrWrEn[k], awReady[k], arReady[k]);
      end
    end
    repeat (3) step();
    drainAndCheck("backpressure");
  endtask

  task automatic test_reset_midstream();
    flushAll();
    step();
    adrFull = 1'b1;
    awValid = 1'b1;
    step();
    awValid = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    adrFull = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (adrWrEn[k] !== 1'b0 || lastGrant[k] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL midreset_dut%0d: wr_en=%b last_grant=%b expected 0 and 1", k, adrWrEn[k], lastGrant[k]);
      end
      checks++;
      if ((statAw[k] !== 16'h0) || (statAr[k] !== 16'h0)) begin
        failures++; $display("[TB] FAIL midreset_stats_dut%0d: got %h/%h expected 0/0", k, statAw[k], statAr[k]);
      end
    end
    flushAll();
    step();
    reset_n = 1'b1;
    step();
    awValid = 1'b1;
    arValid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (awReady[k] !== 1'b1 || arReady[k] !== 1'b0 || adrWrEn[k] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_first_grant_dut%0d: ready=%b%b wr_en=%b expected 10 and 0",
                 k, awReady[k], arReady[k], adrWrEn[k]);
      end
    end
    step();
    drainAndCheck("midreset");
  endtask

  task automatic test_stats();
`ifdef RPC2_CTRL_ADR_ARB_STAT_EN
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    flushAll();
    step();
    arValid = 1'b1;
    repeat (65540) step();
    arValid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (statAr[k] !== 16'hFFFF || statAw[k] !== 16'h0000) begin
        failures++; $display("[TB] FAIL stat_saturate_dut%0d: got aw=%h ar=%h expected 0000/FFFF", k, statAw[k], statAr[k]);
      end
    end
    drainAndCheck("stats");
`else
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (statAr[k] !== 16'h0000 || statAw[k] !== 16'h0000) begin
        failures++; $display("[TB] FAIL stat_absent_dut%0d: got aw=%h ar=%h expected 0000/0000", k, statAw[k], statAr[k]);
      end
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    awValid  = 1'b0;
    arValid  = 1'b0;
    adrFull  = 1'b0;
    for (int k = 0; k < ND; k++) begin
      awSeq[k] = 0;
      arSeq[k] = 0;
    end
    test_reset();
    test_contention();
    test_single_requester();
    test_backpressure();
    test_reset_midstream();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
